e_mdu: RTL
==========

Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the Execute stage of the 5-stage pipeline.
- Consumes the operand pair and decoded MDU op that the D→E pipeline register presents each cycle.
- Owns the HI/LO registers and reports busy/stall status to the hazard unit, which freezes F/D and bubbles E while an MDU op is pending.
- Serves mult, multu, div, divu, mthi and mtlo; mfhi/mflo read the hi/lo outputs directly.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1).
- DIV_CYCLES, 10: busy cycles for div/divu (≥1).

Ports:
- clk  input  1  clock. Reset is reset, synchronous, active-high; clock is clk.
- reset  input  1  synchronous active-high reset.
- start  input  1  E-stage instruction is a valid MDU op this cycle.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- a  input  32  rs operand, already forwarded in E.
- b  input  32  rt operand, already forwarded in E.
- busy  output  1  registered; multi-cycle op in progress.
- stall_req  output  1  combinational: busy | (start & op in 1..4). Hazard unit stalls on this for any MDU-class instruction in D.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (any cycle, including mid-operation):
  - busy=0, hi=0, lo=0, internal counter=0.
  - Pending result is discarded.
  - start is ignored in the reset cycle.
- States: IDLE, RUN.
  - IDLE → RUN on a clock edge where start=1, op∈{1..4}, busy=0.
  - At that edge: latch op, compute the 64-bit result into an internal pending register, load counter with MULT_CYCLES or DIV_CYCLES.
- RUN:
  - busy=1, counter decrements each edge.
  - On the edge where counter==1: hi/lo take the pending result, busy→0, state→IDLE.
- Timing: start sampled at the edge ending cycle T →
  - busy=1 during cycles T+1 .. T+N;
  - new hi/lo visible from cycle T+N+1, same cycle busy reads 0;
  - hi/lo hold their old values throughout RUN.
- mult: signed 32×32 → 64; hi=result[63:32], lo=result[31:0].
- multu: same, unsigned.
- div (signed):
  - lo = quotient, truncated toward zero.
  - hi = remainder, same sign as dividend a.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned quotient/remainder.
- Divide by zero (b==0, div or divu):
  - Still takes DIV_CYCLES with busy asserted.
  - hi and lo retain their previous values at completion.
- mthi / mtlo:
  - With busy=0: hi (resp. lo) ← a at the edge; no busy cycles.
  - With busy=1: ignored.
- start with op∈{1..4} while busy=1: ignored, no restart.
  - Hazard unit must not allow this; the bench checks the block tolerates it.
- start with op 0 or 7: no effect.
- start=0: op, a and b are don't-care.
- hi/lo are stable registered outputs; no combinational path from a/b to hi/lo.

Test Plan:
- reset; mult a=0xFFFFFFFD (−3), b=5 → busy=1 for exactly 5 cycles, hi/lo unchanged during them; next cycle hi=0xFFFFFFFF, lo=0xFFFFFFF1, busy=0.
- multu a=0xFFFFFFFF, b=2 → after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE. Also check stall_req=1 in the start cycle and through every busy cycle.
- div a=0xFFFFFFF9 (−7), b=2 → busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu a=7, b=2 → lo=3, hi=1.
- With hi=0x11, lo=0x22: divu a=7, b=0 → 10 busy cycles, then hi=0x11, lo=0x22 unchanged.
- mult 6×7 started; during busy, apply mthi a=0xAAAA and a second start mult 2×2 → both ignored; final hi=0, lo=42 at cycle T+6. Afterwards mtlo a=0x1234 → lo=0x1234 next cycle with no busy.
- div started; assert reset at busy cycle 3 → next cycle busy=0, hi=0, lo=0; no later update of hi/lo occurs.

Source files
------------

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - Execute-stage multi-cycle multiply/divide unit owning HI/LO.
// The result is computed at launch and held in a pending register until the busy window expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_we;

  logic          is_mdu, is_div, launch, b_zero;
  logic [63:0]   prod_s, prod_u, res;
  logic [31:0]   a_mag, b_mag, den_s, den_u;
  logic [31:0]   qs_mag, rs_mag, qs, rs, qu, ru;

  // Signed divide works on magnitudes so that 0x80000000 / -1 needs no special case.
  always_comb begin
    is_mdu = start && (op >= OP_MULT) && (op <= OP_DIVU);
    is_div = (op == OP_DIV) || (op == OP_DIVU);
    launch = is_mdu && (state == IDLE);
    b_zero = (b == 32'd0);

    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    a_mag  = a[31] ? (~a + 32'd1) : a;
    b_mag  = b[31] ? (~b + 32'd1) : b;
    den_s  = b_zero ? 32'd1 : b_mag;
    den_u  = b_zero ? 32'd1 : b;
    qs_mag = a_mag / den_s;
    rs_mag = a_mag % den_s;
    qs     = (a[31] ^ b[31]) ? (~qs_mag + 32'd1) : qs_mag;
    rs     = a[31] ? (~rs_mag + 32'd1) : rs_mag;
    qu     = a / den_u;
    ru     = a % den_u;

    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = {rs, qs};
      OP_DIVU:  res = {ru, qu};
      default:  res = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (launch) state_n = RUN;
      RUN:  if (cnt == CW'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    stall_req = busy | is_mdu;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (state == IDLE) begin
      if (launch) begin
        cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
        pend_we <= !(is_div && b_zero);
      end else if (start && op == OP_MTHI) begin
        hi <= a;
      end else if (start && op == OP_MTLO) begin
        lo <= a;
      end
    end else begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && pend_we) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule
